pid_sequencer: RTL
==================

PID_SEQUENCER -- requirements
Module: pid_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, width of sensor, engine and control data.
REQ-002 Parameter PER_W, default 16, width of the sample-period register and counter.
REQ-003 Parameter PID_LAT, default 6, cycles from the pid_start cycle until pid_result is valid.
REQ-004 clk  in  1  clock; all logic is on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 enable  in  1  run the control loop.
REQ-007 period  in  PER_W  sample period in cycles; 0 means free-run (back-to-back samples).
REQ-008 sens_valid  in  1  sensor sample offered.
REQ-009 sens_data  in  DATA_W  sensor sample.
REQ-010 sens_ready  out  1  sequencer accepts a sample.
REQ-011 pid_start  out  1  one-cycle start pulse to the PID engine.
REQ-012 pid_data  out  DATA_W  engine input, driven from the capture register.
REQ-013 pid_result  in  DATA_W  engine output.
REQ-014 ctrl_valid  out  1  one-cycle pulse: a new control value is available.
REQ-015 ctrl_data  out  DATA_W  last control value; holds between pulses.
REQ-016 overrun  out  1  sticky flag: a sample tick was missed.
REQ-017 clear_overrun  in  1  clears overrun.
REQ-018 busy  out  1  high in every state except IDLE and WAIT_TICK.
REQ-019 sample_cnt  out  16  count of completed loops; wraps from 0xFFFF to 0.

Function
REQ-020 FSM states: IDLE, WAIT_TICK, WAIT_SENS, START, WAIT_PID, OUTPUT.
REQ-021 IDLE -> WAIT_TICK when enable=1; the tick timer loads period at that edge.
REQ-022 Timer behaviour:
- Decrements every cycle while enable=1.
- At 0 it raises tick for one cycle and reloads period.
- A change to period takes effect at the next reload.
REQ-023 WAIT_TICK -> WAIT_SENS on tick; with period=0 the FSM goes straight to WAIT_SENS and the timer is ignored.
REQ-024 sens_ready=1 only in WAIT_SENS; a transfer is sens_valid&sens_ready; data is captured and the FSM goes to START the next cycle.
REQ-025 START lasts exactly one cycle with pid_start=1; pid_data equals the captured sample in that cycle and is held until the next capture.
REQ-026 WAIT_PID counts PID_LAT-1 cycles; with pid_start in cycle S, OUTPUT is entered in cycle S+PID_LAT.
REQ-027 In OUTPUT: ctrl_valid=1, ctrl_data<=pid_result (registered, visible in the next cycle with ctrl_valid combinational in OUTPUT), sample_cnt increments, FSM -> WAIT_TICK (or WAIT_SENS if period=0); if enable=0 it goes to IDLE.
REQ-028 A tick arriving in any state other than WAIT_TICK sets overrun and is dropped; there is no queuing.
REQ-029 If set and clear occur in the same cycle, set wins.
REQ-030 enable deasserted in WAIT_TICK or WAIT_SENS -> IDLE next cycle; no pid_start is issued.
REQ-031 enable deasserted in START/WAIT_PID/OUTPUT does not abort; the loop completes, ctrl_valid pulses, then the FSM enters IDLE.
REQ-032 The timer is held at 0 and tick is suppressed while enable=0.
REQ-033 pid_start never asserts twice within PID_LAT+1 cycles (engine must return to idle).

Reset
REQ-034 On rst the FSM goes to IDLE and timer, capture register, ctrl_data and sample_cnt clear to 0.
REQ-035 On rst all outputs (sens_ready, pid_start, pid_data, ctrl_valid, ctrl_data, overrun, busy, sample_cnt) read 0.
REQ-036 rst mid-loop discards the in-flight computation; no ctrl_valid follows reset release.

Structure
REQ-037 The FSM state encoding and the PID_LAT default are defined in the shared package pid_pkg, which the PID engine also uses.
REQ-038 The tick timer is one sub-module, pid_tick_timer (enable, period, tick); everything else stays in the top level.

Verification
REQ-039 Basic loop:
- Stimulus: period=20, enable=1, sens_valid=1, sens_data=50000, paired with the real PID engine.
- Required response: pid_start 1 cycle after sens accept; ctrl_valid exactly 6 cycles after pid_start; ctrl_data=engine out; sample_cnt=1.
REQ-040 Overrun:
- Stimulus: period=4 with sens_valid delayed 10 cycles.
- Required response: overrun=1; only one pid_start per completed loop; after clear_overrun, overrun=0.
REQ-041 Free-run:
- Stimulus: period=0, sens_valid=1 constant.
- Required response: pid_start every 8 cycles; overrun stays 0.
REQ-042 Disable mid-compute:
- Stimulus: drop enable 2 cycles after pid_start.
- Required response: ctrl_valid still pulses once, then IDLE; busy=0.
REQ-043 Reset mid-compute:
- Stimulus: assert rst in WAIT_PID.
- Required response: all outputs 0 at once; no ctrl_valid after release.
REQ-044 Counter wrap:
- Stimulus: preload via 65536 loops (or force).
- Required response: sample_cnt wraps 0xFFFF -> 0.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared definitions for the PID control loop: sequencer state encoding and
// the engine latency that both the sequencer and the PID engine agree on.
package pid_pkg;

   localparam int PID_LAT_DEFAULT = 6;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_TICK = 3'd1,
      ST_WAIT_SENS = 3'd2,
      ST_START     = 3'd3,
      ST_WAIT_PID  = 3'd4,
      ST_OUTPUT    = 3'd5
   } pid_state_e;

   // A loop is in flight from sensor wait until the result is published.
   function automatic logic state_busy(input pid_state_e s);
      return !((s == ST_IDLE) || (s == ST_WAIT_TICK));
   endfunction

endpackage

// File: rtl/pid_tick_timer.sv
// Sample-period timer: counts period..0 while enabled, pulses tick at 0 and
// reloads; a new period value is only picked up on a reload.
module pid_tick_timer #(
   parameter int PER_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [PER_W-1:0] period,
   output logic             tick
);

   logic [PER_W-1:0] cnt_q;
   logic             run_q;

   // run_q marks that the counter has been loaded since enable rose.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (!enable) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (!run_q) begin
         cnt_q <= period;
         run_q <= 1'b1;
      end else if (cnt_q == '0) begin
         cnt_q <= period;
      end else begin
         cnt_q <= cnt_q - PER_W'(1);
      end
   end

   assign tick = enable && run_q && (cnt_q == '0);

endmodule

// File: rtl/pid_sequencer.sv
// Sample-loop sequencer: paces sensor capture with the tick timer, launches the
// external PID engine and publishes its result as a control value.
module pid_sequencer
   import pid_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int PER_W   = 16,
   parameter int PID_LAT = PID_LAT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [PER_W-1:0]  period,
   input  logic              sens_valid,
   input  logic [DATA_W-1:0] sens_data,
   output logic              sens_ready,
   output logic              pid_start,
   output logic [DATA_W-1:0] pid_data,
   input  logic [DATA_W-1:0] pid_result,
   output logic              ctrl_valid,
   output logic [DATA_W-1:0] ctrl_data,
   output logic              overrun,
   input  logic              clear_overrun,
   output logic              busy,
   output logic [15:0]       sample_cnt
);

   localparam int               LAT_W    = (PID_LAT > 2) ? $clog2(PID_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((PID_LAT >= 2) ? PID_LAT - 2 : 0);

   pid_state_e        state_q;
   pid_state_e        state_d;
   logic              tick;
   logic              tick_eff;
   logic              free_run;
   logic              xfer;
   logic              ovr_set;
   logic [LAT_W-1:0]  lat_cnt_q;
   logic [DATA_W-1:0] cap_q;
   logic [DATA_W-1:0] ctrl_q;
   logic [15:0]       sample_cnt_q;
   logic              overrun_q;

   pid_tick_timer #(
      .PER_W (PER_W)
   ) u_tick_timer (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .period (period),
      .tick   (tick)
   );

   // In free-run the timer is ignored, so its ticks must not count as missed.
   assign free_run = (period == '0);
   assign tick_eff = tick && !free_run;
   assign xfer     = sens_ready && sens_valid;
   assign ovr_set  = tick_eff && (state_q != ST_WAIT_TICK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (enable) state_d = ST_WAIT_TICK;
         ST_WAIT_TICK: begin
            if (!enable)                   state_d = ST_IDLE;
            else if (free_run || tick_eff) state_d = ST_WAIT_SENS;
         end
         ST_WAIT_SENS: begin
            if (!enable)    state_d = ST_IDLE;
            else if (xfer)  state_d = ST_START;
         end
         ST_START:     state_d = (PID_LAT <= 1) ? ST_OUTPUT : ST_WAIT_PID;
         ST_WAIT_PID:  if (lat_cnt_q == LAT_LAST) state_d = ST_OUTPUT;
         ST_OUTPUT: begin
            if (!enable)      state_d = ST_IDLE;
            else if (free_run) state_d = ST_WAIT_SENS;
            else               state_d = ST_WAIT_TICK;
         end
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sens_ready = 1'b0;
      pid_start  = 1'b0;
      ctrl_valid = 1'b0;
      case (state_q)
         ST_WAIT_SENS: sens_ready = enable;
         ST_START:     pid_start  = 1'b1;
         ST_OUTPUT:    ctrl_valid = 1'b1;
         default:      ;
      endcase
      busy = state_busy(state_q);
   end

   // Engine latency: WAIT_PID covers PID_LAT-1 cycles after the start pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         lat_cnt_q <= '0;
      else if (state_q == ST_WAIT_PID) lat_cnt_q <= lat_cnt_q + LAT_W'(1);
      else                             lat_cnt_q <= '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       cap_q <= '0;
      else if (xfer) cap_q <= sens_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q       <= '0;
         sample_cnt_q <= '0;
      end else if (state_q == ST_OUTPUT) begin
         ctrl_q       <= pid_result;
         sample_cnt_q <= sample_cnt_q + 16'd1;
      end
   end

   // A missed tick outranks a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                overrun_q <= 1'b0;
      else if (ovr_set)       overrun_q <= 1'b1;
      else if (clear_overrun) overrun_q <= 1'b0;
   end

   assign pid_data   = cap_q;
   assign ctrl_data  = ctrl_q;
   assign sample_cnt = sample_cnt_q;
   assign overrun    = overrun_q;

endmodule
